mem_access_unit: RTL and testbench

Load/store initiator driving the byte-wide data memory (32 × 8-bit, combinational read, write on rising clock edge) on behalf of the pipeline's MEM stage. Accepts one byte, halfword or word request at a time. Serialises it into single-byte memory accesses, little-endian, and returns sign- or zero-extended load data with a one-cycle completion pulse. While busy it holds `busy_o` high, and the pipeline stalls on `busy_o`.

---
 rtl/mem_access_unit.sv | 211 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Load/store initiator for the byte-wide data memory used by the MEM stage.
// One byte, halfword or word request is accepted at a time. It is split into
// single-byte memory accesses in little-endian order. Loads return sign- or
// zero-extended data together with a one-cycle completion pulse.
//
// Request handshake:
//   - req_i is sampled only while the unit is idle (busy_o low).
//   - An accepted request raises busy_o from the accepting edge through the
//     done_o cycle, inclusive.
//   - done_o pulses for exactly one cycle, and err_o is valid alongside it.
//   - req_i seen while busy_o is high is dropped, not queued.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       asynchronous reset, active low
//   req_i       request strobe
//   we_i        1 = store, 0 = load
//   size_i      00 byte, 01 halfword, 10 word, 11 illegal
//   sign_i      loads only: 1 = sign-extend, 0 = zero-extend
//   addr_i      byte address
//   wdata_i     store data; the low 8*N bits are used
//   busy_o      request in progress
//   done_o      one-cycle completion pulse
//   err_o       request rejected (valid with done_o)
//   rdata_o     load result; held until the next completion that updates it
//   memRead_o   memory read enable
//   memWrite_o  memory write enable
//   memAddr_o   memory byte address
//   memWData_o  memory write byte
//   memRData_i  memory read byte (combinational, same cycle)
//   dbg_state   current FSM state (0 IDLE, 1 ACCESS, 2 DONE)
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ADDR_W = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        memRead_o,
    output logic        memWrite_o,
    output logic [31:0] memAddr_o,
    output logic [7:0]  memWData_o,
    input  logic [7:0]  memRData_i,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Highest legal byte address in the data memory.
    localparam logic [32:0] LAST_BYTE = 33'((64'd1 << ADDR_W) - 64'd1);

    state_t      state;
    logic        we_q;
    logic        sign_q;
    logic [1:0]  size_q;
    logic [1:0]  k;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rbuf;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    logic [2:0]  req_n;
    logic [32:0] req_last;
    logic        req_err;

    // Rejection is decided entirely at capture time.
    // The 33-bit sum keeps addr + N - 1 from wrapping near 2^32.
    always_comb begin
        req_n    = size_bytes(size_i);
        req_last = {1'b0, addr_i} + {30'd0, req_n} - 33'd1;
        req_err  = (size_i == 2'b11)
                || (size_i == 2'b01 && addr_i[0])
                || (size_i == 2'b10 && addr_i[1:0] != 2'b00)
                || (req_last > LAST_BYTE)
                || ((addr_i >> ADDR_W) != 32'd0);
    end

    logic [1:0]  k_next;
    logic        k_last;
    logic [31:0] load_word;
    logic [31:0] load_ext;

    // load_word merges the byte currently on memRData_i into the partial
    // result. On the last access cycle it can therefore be extended and
    // registered straight into rdata_o on the same edge that enters DONE.
    always_comb begin
        k_next    = k + 2'd1;
        k_last    = (({1'b0, k} + 3'd1) == size_bytes(size_q));
        load_word = rbuf;
        load_word[{k, 3'b000} +: 8] = memRData_i;
        case (size_q)
            2'b00:   load_ext = {{24{sign_q & load_word[7]}}, load_word[7:0]};
            2'b01:   load_ext = {{16{sign_q & load_word[15]}}, load_word[15:0]};
            default: load_ext = load_word;
        endcase
    end

    assign dbg_state = state;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            sign_q     <= 1'b0;
            size_q     <= 2'b00;
            k          <= 2'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rbuf       <= 32'd0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            rdata_o    <= 32'd0;
            memRead_o  <= 1'b0;
            memWrite_o <= 1'b0;
            memAddr_o  <= 32'd0;
            memWData_o <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    err_o  <= 1'b0;
                    if (req_i) begin
                        we_q    <= we_i;
                        sign_q  <= sign_i;
                        size_q  <= size_i;
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        k       <= 2'd0;
                        rbuf    <= 32'd0;
                        busy_o  <= 1'b1;
                        if (req_err) begin
                            // Rejected requests skip memory entirely.
                            state   <= DONE;
                            done_o  <= 1'b1;
                            err_o   <= 1'b1;
                            rdata_o <= 32'd0;
                        end else begin
                            // Present byte 0 during the first ACCESS cycle.
                            state      <= ACCESS;
                            memRead_o  <= ~we_i;
                            memWrite_o <= we_i;
                            memAddr_o  <= addr_i;
                            memWData_o <= we_i ? wdata_i[7:0] : 8'd0;
                        end
                    end
                end

                ACCESS: begin
                    if (!we_q) begin
                        rbuf <= load_word;
                    end
                    if (k_last) begin
                        state      <= DONE;
                        memRead_o  <= 1'b0;
                        memWrite_o <= 1'b0;
                        memAddr_o  <= 32'd0;
                        memWData_o <= 8'd0;
                        done_o     <= 1'b1;
                        err_o      <= 1'b0;
                        if (!we_q) begin
                            rdata_o <= load_ext;
                        end
                    end else begin
                        k          <= k_next;
                        memAddr_o  <= addr_q + {30'd0, k_next};
                        memWData_o <= we_q ? wdata_q[{k_next, 3'b000} +: 8] : 8'd0;
                    end
                end

                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                    err_o  <= 1'b0;
                end

                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                    err_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Bench for mem_access_unit.
// It provides a 32 x 8 memory with combinational read and clocked write.
// A transaction-level reference model tracks the expected memory image, the
// expected load result, the error decision and the completion latency.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int DEPTH = 32;

    logic        clk;
    logic        rst_i;
    logic        req;
    logic        we_in;
    logic [1:0]  size_in;
    logic        sign_in;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [1:0]  dbg_state;

    logic [7:0]  mem     [DEPTH];
    logic [7:0]  exp_mem [DEPTH];
    logic [31:0] exp_rdata;

    int checks   = 0;
    int failures = 0;

    mem_access_unit #(.ADDR_W(5)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .req_i      (req),
        .we_i       (we_in),
        .size_i     (size_in),
        .sign_i     (sign_in),
        .addr_i     (addr_in),
        .wdata_i    (wdata_in),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .rdata_o    (rdata),
        .memRead_o  (mem_read),
        .memWrite_o (mem_write),
        .memAddr_o  (mem_addr),
        .memWData_o (mem_wdata),
        .memRData_i (mem_rdata),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock and memory ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[4:0]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[4:0]] = mem_wdata;
    end

    // ---------------- reference model ----------------
    task automatic model_req(input logic we, input logic [1:0] size, input logic sign,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic e_err, output int e_lat,
                             output int e_rd, output int e_wr);
        int     n;
        longint v;
        n     = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        e_err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
                (size == 2'd2 && addr % 4 != 0) || (longint'(addr) + n - 1 > DEPTH - 1);
        e_rd  = 0;
        e_wr  = 0;
        if (e_err) begin
            e_lat     = 1;
            exp_rdata = 32'd0;
        end else begin
            e_lat = n + 1;
            if (we) begin
                e_wr = n;
                for (int i = 0; i < n; i++) exp_mem[5'(addr + 32'(i))] = 8'(wdata >> (8 * i));
            end else begin
                e_rd = n;
                v    = 0;
                for (int i = 0; i < n; i++) v += longint'(exp_mem[5'(addr + 32'(i))]) << (8 * i);
                if (sign && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
                exp_rdata = 32'(v);
            end
        end
    endtask

    // ---------------- driver ----------------
    // Issues one request at the next falling edge and waits (bounded) for
    // done_o. It records the cycle it was seen and the enable activity.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sign,
                          input logic [31:0] addr, input logic [31:0] wdata, input bit poke,
                          output int lat, output int rd_cyc, output int wr_cyc,
                          output int bad_cyc, output int busy_low, output logic busy_before,
                          output logic err_seen, output logic [31:0] rdata_seen);
        int k;
        bit seen;
        lat = 0; rd_cyc = 0; wr_cyc = 0; bad_cyc = 0; busy_low = 0;
        err_seen = 1'b0; rdata_seen = 32'd0; k = 0; seen = 0;
        @(negedge clk);
        busy_before = busy;
        req = 1'b1; we_in = we; size_in = size; sign_in = sign; addr_in = addr; wdata_in = wdata;
        @(posedge clk);
        #1 req = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            req = (poke && i == 2);
            if (!busy) busy_low++;
            if (mem_read) rd_cyc++;
            if (mem_write) wr_cyc++;
            if (mem_read || mem_write) begin
                if (mem_addr !== addr + 32'(k) || (mem_read && mem_write) ||
                    (mem_write && mem_wdata !== 8'(wdata >> (8 * k)))) bad_cyc++;
                k++;
            end else if (mem_addr !== 32'd0 || mem_wdata !== 8'd0) begin
                bad_cyc++;
            end
            if (done) begin
                seen = 1; lat = i; err_seen = err; rdata_seen = rdata;
            end
        end
        req = 1'b0;
    endtask

    // Shared observation/expectation variables for the tests.
    logic        e_err, err_s, bb;
    int          e_lat, e_rd, e_wr, lat, rd_c, wr_c, bad, bl;
    logic [31:0] rd_s;

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_i = 1'b0; req = 1'b0; we_in = 1'b0; size_in = 2'd0; sign_in = 1'b0;
        addr_in = 32'd0; wdata_in = 32'd0; exp_rdata = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 8'($urandom);
            exp_mem[i] = mem[i];
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, err, mem_read, mem_write, rdata, mem_addr, mem_wdata, dbg_state} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b rd=%b wr=%b rdata=%h addr=%h wdata=%h state=%0d required all zero",
                     busy, done, err, mem_read, mem_write, rdata, mem_addr, mem_wdata, dbg_state);
        end
        rst_i = 1'b1;
    endtask

    task automatic test_word_round_trip();
        model_req(1'b1, 2'd2, 1'b0, 32'd4, 32'hDEADBEEF, e_err, e_lat, e_rd, e_wr);
        do_req(1'b1, 2'd2, 1'b0, 32'd4, 32'hDEADBEEF, 1'b0, lat, rd_c, wr_c, bad, bl, bb, err_s, rd_s);
        checks++; if (lat !== 5) begin failures++; $display("FAIL word_store_latency: got %0d required 5", lat); end
        checks++; if (wr_c !== e_wr || rd_c !== e_rd || bad !== 0) begin failures++;
            $display("FAIL word_store_bus: got wr=%0d rd=%0d bad=%0d required wr=%0d rd=%0d bad=0", wr_c, rd_c, bad, e_wr, e_rd); end
        checks++; if ({mem[7], mem[6], mem[5], mem[4]} !== 32'hDEADBEEF) begin failures++;
            $display("FAIL word_store_bytes: got %h required deadbeef", {mem[7], mem[6], mem[5], mem[4]}); end
        model_req(1'b0, 2'd2, 1'b0, 32'd4, 32'd0, e_err, e_lat, e_rd, e_wr);
        do_req(1'b0, 2'd2, 1'b0, 32'd4, 32'd0, 1'b0, lat, rd_c, wr_c, bad, bl, bb, err_s, rd_s);
        checks++; if (lat !== 5) begin failures++; $display("FAIL word_load_latency: got %0d required 5", lat); end
        checks++; if (rd_s !== 32'hDEADBEEF || err_s !== 1'b0) begin failures++;
            $display("FAIL word_load_data: got %h err=%b required deadbeef err=0", rd_s, err_s); end
        checks++; if (bl !== 0 || bad !== 0 || rd_c !== 4) begin failures++;
            $display("FAIL word_load_bus: got busy_low=%0d bad=%0d rd=%0d required 0 0 4", bl, bad, rd_c); end
    endtask

    task automatic test_extension();
        logic [31:0] req_ref [4];
        logic [34:0] tab [5];
        // {we, size, sign, addr} pairs with their data.
        tab[0] = {1'b1, 2'd0, 1'b0, 32'd9};  req_ref[0] = 32'h00000080;
        tab[1] = {1'b0, 2'd0, 1'b1, 32'd9};  req_ref[1] = 32'hFFFFFF80;
        tab[2] = {1'b0, 2'd0, 1'b0, 32'd9};  req_ref[2] = 32'h00000080;
        tab[3] = {1'b1, 2'd1, 1'b0, 32'd10}; req_ref[3] = 32'h00008001;
        tab[4] = {1'b0, 2'd1, 1'b1, 32'd10};
        for (int t = 0; t < 5; t++) begin
            logic [31:0] wd;
            wd = (t < 4) ? req_ref[t] : 32'd0;
            model_req(tab[t][34], tab[t][33:32], tab[t][31] == 1'b1 ? 1'b0 : 1'b0, 32'd0, 32'd0, e_err, e_lat, e_rd, e_wr);
            exp_rdata = exp_rdata;
        end
    endtask

    task automatic test_extension_run();
        logic [31:0] expect_v [3];
        expect_v[0] = 32'hFFFFFF80; expect_v[1] = 32'h00000080; expect_v[2] = 32'hFFFF8001;
        model_req(1'b1, 2'd0, 1'b0, 32'd9, 32'h00000080, e_err, e_lat, e_rd, e_wr);
        do_req(1'b1, 2'd0, 1'b0, 32'd9, 32'h00000080, 1'b0, lat, rd_c, wr_c, bad, bl, bb, err_s, rd_s);
        checks++; if (mem[9] !== 8'h80 || lat !== 2) begin failures++;
            $display("FAIL byte_store: got mem=%h lat=%0d required 80 2", mem[9], lat); end
        for (int t = 0; t < 2; t++) begin
            model_req(1'b0, 2'd0, (t == 0), 32'd9, 32'd0, e_err, e_lat, e_rd, e_wr);
            do_req(1'b0, 2'd0, (t == 0), 32'd9, 32'd0, 1'b0, lat, rd_c, wr_c, bad, bl, bb, err_s, rd_s);
            checks++; if (rd_s !== expect_v[t] || rd_s !== exp_rdata || lat !== 2) begin failures++;
                $display("FAIL byte_load_ext%0d: got %h lat=%0d required %h lat=2", t, rd_s, lat, expect_v[t]); end
        end
        model_req(1'b1, 2'd1, 1'b0, 32'd10, 32'h00008001, e_err, e_lat, e_rd, e_wr);
        do_req(1'b1, 2'd1, 1'b0, 32'd10, 32'h00008001, 1'b0, lat, rd_c, wr_c, bad, bl, bb, err_s, rd_s);
        checks++; if (rd_s !== 32'h00000080 || lat !== 3 || {mem[11], mem[10]} !== 16'h8001) begin failures++;
            $display("FAIL half_store: got rdata=%h lat=%0d mem=%h required 00000080 3 8001", rd_s, lat, {mem[11], mem[10]}); end
        model_req(1'b0, 2'd1, 1'b1, 32'd10, 32'd0, e_err, e_lat, e_rd, e_wr);
        do_req(1'b0, 2'd1, 1'b1, 32'd10, 32'd0, 1'b0, lat, rd_c, wr_c, bad, bl, bb, err_s, rd_s);
        checks++; if (rd_s !== expect_v[2] || lat !== 3) begin failures++;
            $display("FAIL half_load_signed: got %h lat=%0d required %h lat=3", rd_s, lat, expect_v[2]); end
    endtask

    task automatic test_errors();
        logic [34:0] tab [5];
        tab[0] = {1'b0, 2'd2, 32'd2};
        tab[1] = {1'b0, 2'd1, 32'd31};
        tab[2] = {1'b0, 2'd3, 32'd0};
        tab[3] = {1'b0, 2'd0, 32'h20};
        tab[4] = {1'b1, 2'd0, 32'h100};
        for (int t = 0; t < 5; t++) begin
            // A good word load first, so a forced-zero rdata is visible.
            model_req(1'b0, 2'd2, 1'b0, 32'd4, 32'd0, e_err, e_lat, e_rd, e_wr);
            do_req(1'b0, 2'd2, 1'b0, 32'd4, 32'd0, 1'b0, lat, rd_c, wr_c, bad, bl, bb, err_s, rd_s);
            checks++; if (rd_s !== exp_rdata) begin failures++;
                $display("FAIL err%0d_preload: got %h required %h", t, rd_s, exp_rdata); end
            model_req(tab[t][34], tab[t][33:32], 1'b0, tab[t][31:0], 32'h5A5A5A5A, e_err, e_lat, e_rd, e_wr);
            do_req(tab[t][34], tab[t][33:32], 1'b0, tab[t][31:0], 32'h5A5A5A5A, 1'b0, lat, rd_c, wr_c, bad, bl, bb, err_s, rd_s);
            checks++; if (lat !== 1 || err_s !== 1'b1 || rd_s !== 32'd0 || rd_c + wr_c !== 0 || bad !== 0) begin failures++;
                $display("FAIL err%0d_case: got lat=%0d err=%b rdata=%h en=%0d bad=%0d required 1 1 0 0 0",
                         t, lat, err_s, rd_s, rd_c + wr_c, bad); end
        end
    endtask

    task automatic test_busy_ignore();
        int extra_done, extra_busy;
        model_req(1'b0, 2'd2, 1'b0, 32'd4, 32'd0, e_err, e_lat, e_rd, e_wr);
        do_req(1'b0, 2'd2, 1'b0, 32'd4, 32'd0, 1'b1, lat, rd_c, wr_c, bad, bl, bb, err_s, rd_s);
        checks++; if (lat !== 5 || rd_c !== 4 || rd_s !== exp_rdata) begin failures++;
            $display("FAIL busy_poke_txn: got lat=%0d rd=%0d rdata=%h required 5 4 %h", lat, rd_c, rd_s, exp_rdata); end
        extra_done = 0; extra_busy = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) extra_done++;
            if (busy) extra_busy++;
        end
        checks++; if (extra_done !== 0 || extra_busy !== 0) begin failures++;
            $display("FAIL busy_poke_ignored: got done=%0d busy=%0d extra cycles required 0 0", extra_done, extra_busy); end
    endtask

    task automatic test_reset_mid_store();
        model_req(1'b1, 2'd2, 1'b0, 32'd0, 32'hA5A5A5A5, e_err, e_lat, e_rd, e_wr);
        do_req(1'b1, 2'd2, 1'b0, 32'd0, 32'hA5A5A5A5, 1'b0, lat, rd_c, wr_c, bad, bl, bb, err_s, rd_s);
        @(negedge clk);
        req = 1'b1; we_in = 1'b1; size_in = 2'd2; sign_in = 1'b0; addr_in = 32'd0; wdata_in = 32'h11223344;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, mem_read, mem_write, rdata, mem_addr, mem_wdata, dbg_state} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: got busy=%b done=%b err=%b rd=%b wr=%b rdata=%h addr=%h state=%0d required all zero",
                     busy, done, err, mem_read, mem_write, rdata, mem_addr, dbg_state);
        end
        exp_mem[0] = 8'h44; exp_mem[1] = 8'h33; exp_rdata = 32'd0;
        checks++; if ({mem[3], mem[2], mem[1], mem[0]} !== {exp_mem[3], exp_mem[2], exp_mem[1], exp_mem[0]}) begin failures++;
            $display("FAIL midreset_bytes: got %h required %h", {mem[3], mem[2], mem[1], mem[0]},
                     {exp_mem[3], exp_mem[2], exp_mem[1], exp_mem[0]}); end
        @(negedge clk);
        rst_i = 1'b1;
    endtask

    task automatic test_back_to_back();
        model_req(1'b0, 2'd0, 1'b0, 32'd0, 32'd0, e_err, e_lat, e_rd, e_wr);
        do_req(1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 1'b0, lat, rd_c, wr_c, bad, bl, bb, err_s, rd_s);
        checks++; if (rd_s !== exp_rdata || lat !== 2 || bl !== 0) begin failures++;
            $display("FAIL b2b_first: got %h lat=%0d busy_low=%0d required %h 2 0", rd_s, lat, bl, exp_rdata); end
        model_req(1'b0, 2'd0, 1'b0, 32'd31, 32'd0, e_err, e_lat, e_rd, e_wr);
        do_req(1'b0, 2'd0, 1'b0, 32'd31, 32'd0, 1'b0, lat, rd_c, wr_c, bad, bl, bb, err_s, rd_s);
        checks++; if (rd_s !== exp_rdata || lat !== 2) begin failures++;
            $display("FAIL b2b_second: got %h lat=%0d required %h 2", rd_s, lat, exp_rdata); end
        checks++; if (bb !== 1'b0 || bl !== 0) begin failures++;
            $display("FAIL b2b_gap: got busy_in_gap=%b busy_low_after=%0d required 0 0", bb, bl); end
    endtask

    task automatic test_random();
        logic        we, sign;
        logic [1:0]  size;
        logic [31:0] addr, wdata;
        int          mm;
        for (int t = 0; t < 40; t++) begin
            we    = 1'($urandom_range(0, 1));
            sign  = 1'($urandom_range(0, 1));
            size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            addr  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom_range(0, 31));
            if ($urandom_range(0, 3) != 0 && size != 2'd3) addr = addr & ~((32'd1 << size) - 32'd1);
            wdata = $urandom;
            model_req(we, size, sign, addr, wdata, e_err, e_lat, e_rd, e_wr);
            do_req(we, size, sign, addr, wdata, 1'b0, lat, rd_c, wr_c, bad, bl, bb, err_s, rd_s);
            checks++; if (lat !== e_lat || err_s !== e_err || rd_s !== exp_rdata) begin failures++;
                $display("FAIL rand%0d_result: we=%b size=%0d addr=%h got lat=%0d err=%b rdata=%h required %0d %b %h",
                         t, we, size, addr, lat, err_s, rd_s, e_lat, e_err, exp_rdata); end
            checks++; if (rd_c !== e_rd || wr_c !== e_wr || bad !== 0 || bl !== 0) begin failures++;
                $display("FAIL rand%0d_bus: got rd=%0d wr=%0d bad=%0d busy_low=%0d required %0d %0d 0 0",
                         t, rd_c, wr_c, bad, bl, e_rd, e_wr); end
            mm = 0;
            for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_mem[i]) mm++;
            checks++; if (mm !== 0) begin failures++;
                $display("FAIL rand%0d_memory: got %0d differing bytes required 0", t, mm); end
        end
    endtask

    initial begin
        test_reset();
        test_word_round_trip();
        test_extension_run();
        test_errors();
        test_busy_ignore();
        test_reset_mid_store();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
